// File: rtl/uart_pkg.sv
// Shared defaults and helpers for the UART receive datapath.
// Parity support is controlled by the UART_RX_PARITY_EN macro.
package uart_pkg;
  localparam int DATA_BITS_DEF = 8;
  localparam int STOP_BITS_DEF = 1;
`ifdef UART_RX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  function automatic int cnt_w(input int total);
    return $clog2(total + 1);
  endfunction
endpackage

// File: rtl/uart_rx_bit_counter.sv
// Saturating frame-bit counter with a clear and an enable.
// The terminal flag is registered from the next count, so it rises the cycle after the last sample.
module uart_rx_bit_counter #(
  parameter int TOTAL = 9,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         done
);
  logic [W-1:0] count_nxt;

  always_comb begin
    count_nxt = count;
    if (clr)                           count_nxt = '0;
    else if (en && count != W'(TOTAL)) count_nxt = count + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      done  <= 1'b0;
    end else begin
      count <= count_nxt;
      done  <= (count_nxt == W'(TOTAL));
    end
  end
endmodule

// File: rtl/uart_rx_datapath.sv
// UART receive datapath: frame shift register, bit counter, holding register and error flags.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_datapath
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int STOP_BITS = STOP_BITS_DEF
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 shift_pulse,
  input  logic                 done_pulse,
  output logic                 count_done,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  input  logic                 err_clr
);
  localparam int TOTAL = DATA_BITS + PARITY_BITS + STOP_BITS;
  localparam int CW    = cnt_w(TOTAL);

  logic [TOTAL-1:0] sreg, frame;
  logic [CW-1:0]    count;
  logic             sample, load, ovr;

  // done_pulse wins over a coincident sample; a full counter ignores samples
  assign sample = shift_pulse && !done_pulse && (count != CW'(TOTAL));
  assign load   = done_pulse && (!rx_valid || rx_ready);
  assign ovr    = done_pulse && rx_valid && !rx_ready;

  // Right-align a short frame so unsampled positions (including stop bits) read 0
  assign frame = sreg >> (CW'(TOTAL) - count);

  uart_rx_bit_counter #(.TOTAL(TOTAL), .W(CW)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (done_pulse),
    .en    (sample),
    .count (count),
    .done  (count_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg        <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      if (done_pulse)  sreg <= '0;
      else if (sample) sreg <= {rx, sreg[TOTAL-1:1]};

      if (load) begin
        rx_data    <= frame[DATA_BITS-1:0];
        frame_err  <= ~&frame[TOTAL-1 -: STOP_BITS];
        rx_valid   <= 1'b1;
`ifdef UART_RX_PARITY_EN
        parity_err <= ((^frame[DATA_BITS-1:0]) ^ frame[DATA_BITS]) != PARITY_ODD;
`endif
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      if (ovr)          overrun_err <= 1'b1;
      else if (err_clr) overrun_err <= 1'b0;
    end
  end
endmodule
